// File: rtl/iommu_hpm_pkg.sv
// rtl/iommu_hpm_pkg.sv - shared event IDs, tag/entry types and helpers for the HPM event generator
package iommu_hpm_pkg;

    // Event IDs as seen by the HPM counters; strobe bit k-1 carries ID k
    localparam int HPM_EVT_NONE        = 0;
    localparam int HPM_EVT_UNTRANS_REQ = 1;
    localparam int HPM_EVT_TRANS_REQ   = 2;
    localparam int HPM_EVT_ATS_REQ     = 3;
    localparam int HPM_EVT_IOTLB_MISS  = 4;
    localparam int HPM_EVT_DDT_WALK    = 5;
    localparam int HPM_EVT_PDT_WALK    = 6;
    localparam int HPM_EVT_S_PTW       = 7;
    localparam int HPM_EVT_G_PTW       = 8;

    localparam int HPM_EVT_W = 8;
    localparam int HPM_ID_W  = 15;

    typedef struct packed {
        logic [23:0] did;
        logic [19:0] pid;
        logic        pscv;
        logic [15:0] gscid;
        logic        idt;
    } hpm_tag_t;

    typedef struct packed {
        logic [HPM_EVT_W-1:0] pend;
        hpm_tag_t             tag;
    } hpm_evt_entry_t;

    // Event ID of the lowest pending strobe bit, 0 when nothing is pending
    function automatic logic [HPM_ID_W-1:0] hpm_first_id(input logic [HPM_EVT_W-1:0] pend);
        logic [HPM_ID_W-1:0] id;
        id = '0;
        for (int k = HPM_EVT_W - 1; k >= 0; k--) begin
            if (pend[k]) begin
                id = HPM_ID_W'(k + 1);
            end
        end
        return id;
    endfunction

    // Number of strobes set in one event vector
    function automatic logic [3:0] hpm_popcount(input logic [HPM_EVT_W-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < HPM_EVT_W; k++) begin
            c = c + {3'd0, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/iommu_hpm_evt_fifo.sv
// rtl/iommu_hpm_evt_fifo.sv - event entry FIFO with in-place head pend-mask clearing
module iommu_hpm_evt_fifo
    import iommu_hpm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  hpm_evt_entry_t       push_data_i,
    input  logic                 pop_i,
    input  logic                 clr_i,
    input  logic [HPM_EVT_W-1:0] clr_mask_i,
    output hpm_evt_entry_t       head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(DEPTH);

    hpm_evt_entry_t mem_q [DEPTH];
    hpm_evt_entry_t mem_d [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_idx, rd_idx;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_idx];

    // Next storage/pointer state: head bit clear, pop, then tail write (tail may reuse a popped head slot)
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            mem_d[rd_idx].pend = mem_q[rd_idx].pend & ~clr_mask_i;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
        if (push_i) begin
            mem_d[wr_idx] = push_data_i;
            wr_ptr_d      = wr_ptr_q + (AW + 1)'(1);
        end
    end

    // Storage needs no reset; the pointers alone define which slots are live
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/iommu_hpm_evt_gen.sv
// rtl/iommu_hpm_evt_gen.sv - serializes translation event strobes onto the HPM event channel (optional IOMMU_HPM_DROP_CNT_EN)
module iommu_hpm_evt_gen #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        evt_i,
    input  logic [23:0]       did_i,
    input  logic [19:0]       pid_i,
    input  logic              pscv_i,
    input  logic [15:0]       gscid_i,
    input  logic              idt_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [14:0]       evt_id_o,
    output logic [23:0]       evt_did_o,
    output logic [19:0]       evt_pid_o,
    output logic              evt_pscv_o,
    output logic [15:0]       evt_gscid_o,
    output logic              evt_idt_o,
`ifdef IOMMU_HPM_DROP_CNT_EN
    output logic [DROP_W-1:0] drop_cnt_o,
`endif
    output logic              drop_o
);

    import iommu_hpm_pkg::*;

    hpm_evt_entry_t       head;
    hpm_evt_entry_t       push_data;
    hpm_tag_t             tag_out;
    logic                 full, empty;
    logic [HPM_EVT_W-1:0] sel_onehot;
    logic                 accept, last_bit, pop, clr, evt_nz, push, drop;
    logic                 drop_q, drop_d;

    assign push_data.pend      = evt_i;
    assign push_data.tag.did   = did_i;
    assign push_data.tag.pid   = pid_i;
    assign push_data.tag.pscv  = pscv_i;
    assign push_data.tag.gscid = gscid_i;
    assign push_data.tag.idt   = idt_i;

    iommu_hpm_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .clr_i       (clr),
        .clr_mask_i  (sel_onehot),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Lowest pending bit of the head is the presented event; the entry pops with its last bit
    always_comb begin
        sel_onehot = head.pend & (~head.pend + 8'd1);
        accept     = evt_valid_o & evt_ready_i;
        last_bit   = (head.pend & ~sel_onehot) == '0;
        pop        = accept & last_bit;
        clr        = accept & ~last_bit;
        evt_nz     = |evt_i;
        push       = evt_nz & (~full | pop);
        drop       = evt_nz & full & ~pop;
        drop_d     = drop;
    end

    // Output fields come straight from the registered head; zeroed while nothing is buffered
    always_comb begin
        evt_valid_o = ~empty;
        evt_id_o    = '0;
        tag_out     = '0;
        if (!empty) begin
            evt_id_o = hpm_first_id(head.pend);
            tag_out  = head.tag;
        end
        evt_did_o   = tag_out.did;
        evt_pid_o   = tag_out.pid;
        evt_pscv_o  = tag_out.pscv;
        evt_gscid_o = tag_out.gscid;
        evt_idt_o   = tag_out.idt;
    end

    // Drop pulse lags the discarded strobe by one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_o = drop_q;

`ifdef IOMMU_HPM_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_W:0]   drop_sum;

    // Count every discarded strobe, sticking at all-ones instead of wrapping
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_W + 1)'(hpm_popcount(evt_i));
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

    // Drop counter register; cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_drop_w;
    assign unused_drop_w = (DROP_W > 0);
`endif

endmodule

// File: tb/tb_iommu_hpm_evt_gen.sv
// tb/tb_iommu_hpm_evt_gen.sv - directed scoreboard bench for iommu_hpm_evt_gen
module tb_iommu_hpm_evt_gen;

    typedef struct packed {
        logic [14:0] id;
        logic [23:0] did;
        logic [19:0] pid;
        logic        pscv;
        logic [15:0] gscid;
        logic        idt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  evt;
    logic [23:0] did;
    logic [19:0] pid;
    logic        pscv;
    logic [15:0] gscid;
    logic        idt;
    logic        ready;
    logic        evt_valid_o;
    logic [14:0] evt_id_o;
    logic [23:0] evt_did_o;
    logic [19:0] evt_pid_o;
    logic        evt_pscv_o;
    logic [15:0] evt_gscid_o;
    logic        evt_idt_o;
    logic        drop_o;
`ifdef IOMMU_HPM_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];

    always #5 clk = ~clk;

    iommu_hpm_evt_gen #(
        .DEPTH  (4),
        .DROP_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .evt_i       (evt),
        .did_i       (did),
        .pid_i       (pid),
        .pscv_i      (pscv),
        .gscid_i     (gscid),
        .idt_i       (idt),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (ready),
        .evt_id_o    (evt_id_o),
        .evt_did_o   (evt_did_o),
        .evt_pid_o   (evt_pid_o),
        .evt_pscv_o  (evt_pscv_o),
        .evt_gscid_o (evt_gscid_o),
        .evt_idt_o   (evt_idt_o),
`ifdef IOMMU_HPM_DROP_CNT_EN
        .drop_cnt_o  (drop_cnt_o),
`endif
        .drop_o      (drop_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one strobe vector after the edge; expected records are queued in ascending ID order
    task automatic send(input logic [7:0] e, input logic [23:0] d, input logic [19:0] p,
                        input logic ps, input logic [15:0] g, input logic it, input bit accepted);
        rec_t r;
        @(posedge clk);
        #1;
        evt = e; did = d; pid = p; pscv = ps; gscid = g; idt = it;
        if (accepted) begin
            for (int k = 0; k < 8; k++) begin
                if (e[k]) begin
                    r.id = 15'(k + 1); r.did = d; r.pid = p; r.pscv = ps; r.gscid = g; r.idt = it;
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic idle_evt();
        @(posedge clk);
        #1;
        evt = 8'h00;
    endtask

    // Scoreboard: every accepted record must match the oldest expected one
    always @(negedge clk) begin
        rec_t obs;
        rec_t e;
        if (!rst && evt_valid_o && ready) begin
            obs = {evt_id_o, evt_did_o, evt_pid_o, evt_pscv_o, evt_gscid_o, evt_idt_o};
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected: observed id=%0d did=%0h expected none", evt_id_o, evt_did_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert (obs === e) else begin
                    bad++;
                    $error("FAIL sb_record: observed id=%0d did=%0h pid=%0h gscid=%0h expected id=%0d did=%0h pid=%0h gscid=%0h",
                           obs.id, obs.did, obs.pid, obs.gscid, e.id, e.did, e.pid, e.gscid);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; evt = '0; did = '0; pid = '0; pscv = 1'b0; gscid = '0; idt = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(evt_valid_o), 64'd0);
        chk("rst_id", 64'(evt_id_o), 64'd0);
        chk("rst_did", 64'(evt_did_o), 64'd0);
        chk("rst_gscid", 64'(evt_gscid_o), 64'd0);
        chk("rst_drop", 64'(drop_o), 64'd0);
`ifdef IOMMU_HPM_DROP_CNT_EN
        chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
`endif

        // Single IOTLB miss: one-cycle latency, gone the cycle after acceptance
        send(8'h08, 24'h012345, 20'hABCDE, 1'b1, 16'h5A5A, 1'b0, 1'b1);
        @(negedge clk);
        chk("single_no_comb", 64'(evt_valid_o), 64'd0);
        idle_evt();
        @(negedge clk);
        chk("single_valid", 64'(evt_valid_o), 64'd1);
        chk("single_id", 64'(evt_id_o), 64'd4);
        chk("single_did", 64'(evt_did_o), 64'h12345);
        @(negedge clk);
        chk("single_valid_low", 64'(evt_valid_o), 64'd0);

        // Multi-bit entry drains IDs 1, 3, 8 back to back
        send(8'b1000_0101, 24'hABCDEF, 20'h00011, 1'b0, 16'h1234, 1'b1, 1'b1);
        idle_evt();
        @(negedge clk);
        chk("multi_id1", 64'(evt_id_o), 64'd1);
        @(negedge clk);
        chk("multi_id3", 64'(evt_id_o), 64'd3);
        chk("multi_tag3", 64'(evt_did_o), 64'hABCDEF);
        @(negedge clk);
        chk("multi_id8", 64'(evt_id_o), 64'd8);
        chk("multi_idt8", 64'(evt_idt_o), 64'd1);
        @(negedge clk);
        chk("multi_done", 64'(evt_valid_o), 64'd0);

        // Ready low: four entries fill the FIFO, the fifth is dropped
        @(posedge clk);
        #1;
        ready = 1'b0;
        send(8'h01, 24'h000101, 20'h00001, 1'b1, 16'h0001, 1'b0, 1'b1);
        send(8'h02, 24'h000202, 20'h00002, 1'b0, 16'h0002, 1'b1, 1'b1);
        send(8'h04, 24'h000303, 20'h00003, 1'b1, 16'h0003, 1'b0, 1'b1);
        send(8'h08, 24'h000404, 20'h00004, 1'b0, 16'h0004, 1'b1, 1'b1);
        send(8'h10, 24'h000505, 20'h00005, 1'b1, 16'h0005, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_not_yet", 64'(drop_o), 64'd0);
        idle_evt();
        @(negedge clk);
        chk("drop_pulse", 64'(drop_o), 64'd1);
`ifdef IOMMU_HPM_DROP_CNT_EN
        chk("drop_cnt_one", 64'(drop_cnt_o), 64'd1);
`endif
        @(negedge clk);
        chk("drop_pulse_end", 64'(drop_o), 64'd0);
        chk("full_head_id", 64'(evt_id_o), 64'd1);
        chk("full_head_did", 64'(evt_did_o), 64'h000101);

        // Full FIFO: push in the same cycle as the head's last-bit pop is accepted
        send(8'h03, 24'h0C0C0C, 20'h0CCCC, 1'b1, 16'hC0C0, 1'b1, 1'b1);
        ready = 1'b1;
        idle_evt();
        @(negedge clk);
        chk("pushpop_no_drop", 64'(drop_o), 64'd0);
`ifdef IOMMU_HPM_DROP_CNT_EN
        chk("pushpop_cnt_hold", 64'(drop_cnt_o), 64'd1);
`endif
        repeat (10) @(negedge clk);
        chk("pushpop_drained", 64'(exp_q.size()), 64'd0);
        chk("pushpop_idle", 64'(evt_valid_o), 64'd0);

        // Ready 0-1-0-1: held records stay stable while not accepted
        @(posedge clk);
        #1;
        ready = 1'b0;
        send(8'h30, 24'h777777, 20'h77777, 1'b1, 16'h7777, 1'b0, 1'b1);
        idle_evt();
        @(negedge clk);
        chk("hold5_a_id", 64'(evt_id_o), 64'd5);
        @(negedge clk);
        chk("hold5_b_id", 64'(evt_id_o), 64'd5);
        chk("hold5_b_did", 64'(evt_did_o), 64'h777777);
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        @(negedge clk);
        chk("hold6_a_id", 64'(evt_id_o), 64'd6);
        @(negedge clk);
        chk("hold6_b_id", 64'(evt_id_o), 64'd6);
        chk("hold6_b_pid", 64'(evt_pid_o), 64'h77777);
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_done", 64'(evt_valid_o), 64'd0);

        // Reset with three entries pending discards them without counting drops
        @(posedge clk);
        #1;
        ready = 1'b0;
        send(8'h01, 24'h0000AA, 20'h000AA, 1'b0, 16'h00AA, 1'b0, 1'b0);
        send(8'h02, 24'h0000BB, 20'h000BB, 1'b0, 16'h00BB, 1'b0, 1'b0);
        send(8'h04, 24'h0000CC, 20'h000CC, 1'b0, 16'h00CC, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        evt = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(evt_valid_o), 64'd0);
        chk("mid_rst_drop", 64'(drop_o), 64'd0);
`ifdef IOMMU_HPM_DROP_CNT_EN
        chk("mid_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
`endif
        ready = 1'b1;
        send(8'h80, 24'hFEDCBA, 20'hFEDCB, 1'b1, 16'hFEDC, 1'b1, 1'b1);
        idle_evt();
        @(negedge clk);
        chk("post_rst_id", 64'(evt_id_o), 64'd8);
        chk("post_rst_gscid", 64'(evt_gscid_o), 64'hFEDC);
        repeat (3) @(negedge clk);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("final_idle", 64'(evt_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
